// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single main-memory port between the I-cache and D-cache.
// Each grant becomes a word-serial burst of LINE_WORDS accesses that ends in one done pulse.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic [31:0]                   i_rdata,
  output logic                          i_rvalid,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [31:0]                   d_wdata,
  output logic [31:0]                   d_rdata,
  output logic                          d_rvalid,
  output logic                          d_done,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_din,
  input  logic [31:0]                   mem_dout,
  input  logic                          mem_ack
);

  // Handshake: a requester holds req (level) until its done pulse and changes it in the
  // cycle after done; memory completes the presented word in any cycle it raises mem_ack
  // while mem_cs is high, and mem_cs/mem_addr/mem_we/mem_din stay stable until then.

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [CW-1:0]     LAST_IDX = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] base;
  logic              gnt_d;
  logic              last_d;
  logic              pick_d;
  logic [ADDR_W-1:0] req_addr;
  logic              rd_ack;

  // On a tie the cache that was not served last wins; last_d resets to I-cache.
  always_comb begin
    pick_d   = d_req & (~i_req | ~last_d);
    req_addr = pick_d ? d_addr : i_addr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      base   <= '0;
      gnt_d  <= 1'b0;
      last_d <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            gnt_d  <= pick_d;
            base   <= req_addr & ~OFF_MASK;
            cnt    <= '0;
            mem_cs <= 1'b1;
            mem_we <= pick_d & d_we;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (cnt == LAST_IDX) begin
              mem_cs <= 1'b0;
              mem_we <= 1'b0;
              i_done <= ~gnt_d;
              d_done <= gnt_d;
              state  <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          last_d <= gnt_d;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is forwarded in the ack cycle; a reset in that cycle suppresses it.
  assign rd_ack   = mem_cs & ~mem_we & mem_ack & ~reset;
  assign i_rvalid = rd_ack & ~gnt_d;
  assign d_rvalid = rd_ack & gnt_d;
  assign i_rdata  = i_rvalid ? mem_dout : 32'h0;
  assign d_rdata  = d_rvalid ? mem_dout : 32'h0;

  assign mem_addr = mem_cs ? base + (ADDR_W'(cnt) << 2) : '0;
  assign word_idx = mem_cs ? cnt : '0;
  assign mem_din  = (mem_cs & gnt_d) ? d_wdata : 32'h0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a burst-queue model is compared every cycle,
// and literal latencies/addresses/grant orders pin the model.
module tb_cache_mem_arbiter;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int IW = $clog2(LW);

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata, mem_dout;
  logic [31:0]   i_rdata, d_rdata, mem_din;
  logic          i_rvalid, i_done, d_rvalid, d_done, mem_cs, mem_we;
  logic [IW-1:0] word_idx;
  logic [AW-1:0] mem_addr;

  cache_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done), .word_idx(word_idx),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: a queue of word addresses per granted burst ----------------
  int          m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
  int          m_last  = 1;   // cache served last
  bit          m_wr    = 1'b0;
  bit          m_done_now = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] wb_line [LW];

  logic [31:0] ack_log[$];
  int          done_who[$];
  int          i_rv_cnt, d_rv_cnt, i_done_cnt, d_done_cnt, hold8;

  always @(negedge clock) begin : compare_proc
    bit          e_cs;
    int          e_idx;
    bit          e_irv, e_drv;
    logic [31:0] e_din;
    int          w;
    logic [31:0] a;
    e_cs  = exp_q.size() > 0;
    e_idx = e_cs ? LW - exp_q.size() : 0;
    e_irv = e_cs && m_owner == 1 && !m_wr && mem_ack;
    e_drv = e_cs && m_owner == 2 && !m_wr && mem_ack;
    e_din = (e_cs && m_owner == 2) ? wb_line[e_idx] : 32'h0;
    // the cycle in which reset first rises is left unchecked
    if (!(reset && !rst_seen)) begin
      check("mem_cs", 32'(mem_cs), 32'(e_cs));
      check("mem_we", 32'(mem_we), 32'(e_cs && m_wr));
      check("mem_din", mem_din, e_din);
      if (e_cs || reset) begin
        check("mem_addr", mem_addr, e_cs ? exp_q[0] : 32'h0);
        check("word_idx", 32'(word_idx), 32'(e_idx));
      end
      check("i_rvalid", 32'(i_rvalid), 32'(e_irv));
      check("d_rvalid", 32'(d_rvalid), 32'(e_drv));
      check("i_rdata", i_rdata, e_irv ? mem_dout : 32'h0);
      check("d_rdata", d_rdata, e_drv ? mem_dout : 32'h0);
      check("i_done", 32'(i_done), 32'(m_done_now && m_owner == 1));
      check("d_done", 32'(d_done), 32'(m_done_now && m_owner == 2));
      if (mem_cs && mem_ack) ack_log.push_back(mem_addr);
      if (mem_cs && mem_addr == 32'h48) hold8++;
      if (i_rvalid) i_rv_cnt++;
      if (d_rvalid) d_rv_cnt++;
      if (i_done) begin i_done_cnt++; done_who.push_back(1); end
      if (d_done) begin d_done_cnt++; done_who.push_back(2); end
    end
    // advance the model with the inputs the next edge will sample
    if (reset) begin
      m_owner = 0; m_last = 1; m_wr = 1'b0; m_done_now = 1'b0;
      exp_q.delete();
    end else if (m_done_now) begin
      m_last = m_owner; m_owner = 0; m_done_now = 1'b0;
    end else if (exp_q.size() > 0) begin
      if (mem_ack) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done_now = 1'b1;
      end
    end else if (i_req || d_req) begin
      w = (d_req && (!i_req || m_last == 1)) ? 2 : 1;
      a = (w == 2) ? d_addr : i_addr;
      a = a & ~32'(LW * 4 - 1);
      m_owner = w;
      m_wr = (w == 2) && d_we;
      for (int k = 0; k < LW; k++) exp_q.push_back(a + 32'(4 * k));
    end
  end

  // ---------------- memory / D-cache responder ----------------
  int waits_left = 0;
  initial begin
    mem_ack = 1'b1; mem_dout = 32'h0; d_wdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      mem_dout = $urandom;
      d_wdata  = wb_line[word_idx];
      if (mem_cs && word_idx == 2'd2 && waits_left > 0) begin
        mem_ack = 1'b0;
        waits_left--;
      end else begin
        mem_ack = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    ack_log.delete(); done_who.delete();
    i_rv_cnt = 0; d_rv_cnt = 0; i_done_cnt = 0; d_done_cnt = 0; hold8 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic run_burst(input bit is_d, input bit we, input logic [31:0] addr, output int lat);
    int  start;
    bit  found;
    start = cyc;
    found = 1'b0;
    lat   = -1;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; end
    else begin i_req = 1'b1; i_addr = addr; end
    for (int n = 0; n < 60 && !found; n++) begin
      step();
      if (is_d ? d_done : i_done) begin found = 1'b1; lat = cyc - start; end
    end
    if (!found) check("burst_timeout", 32'd0, 32'd1);
    step();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic check_acks(input string name, input logic [31:0] base);
    check({name, "_ack_count"}, 32'(ack_log.size()), 32'(LW));
    for (int k = 0; k < LW; k++)
      if (k < ack_log.size()) check({name, "_ack_addr"}, ack_log[k], base + 32'(4 * k));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat, ni, nd, c1, c2;
    bit drop_i, drop_d, found;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0;
    for (int k = 0; k < LW; k++) wb_line[k] = 32'h0;
    do_reset();
    step();

    // D refill from an unaligned address
    clear_logs();
    run_burst(1'b1, 1'b0, 32'h18, lat);
    check("t1_latency", 32'(lat), 32'd5);
    check_acks("t1", 32'h10);
    check("t1_d_rvalid_count", 32'(d_rv_cnt), 32'd4);
    check("t1_i_rvalid_count", 32'(i_rv_cnt), 32'd0);
    check("t1_i_done_count", 32'(i_done_cnt), 32'd0);
    step();

    // D write-back
    for (int k = 0; k < LW; k++) wb_line[k] = $urandom;
    clear_logs();
    run_burst(1'b1, 1'b1, 32'h84, lat);
    check_acks("t2", 32'h80);
    check("t2_d_rvalid_count", 32'(d_rv_cnt), 32'd0);
    check("t2_d_done_count", 32'(d_done_cnt), 32'd1);
    step();

    // simultaneous requests after reset, each re-requested once
    do_reset();
    clear_logs();
    i_addr = 32'h04; d_addr = 32'h84; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    ni = 0; nd = 0; drop_i = 0; drop_d = 0;
    for (int n = 0; n < 100 && !(ni == 2 && nd == 2); n++) begin
      step();
      if (drop_i) begin i_req = 1'b0; drop_i = 1'b0; end
      if (drop_d) begin d_req = 1'b0; drop_d = 1'b0; end
      if (i_done) begin ni++; if (ni == 2) drop_i = 1'b1; end
      if (d_done) begin nd++; if (nd == 2) drop_d = 1'b1; end
    end
    step();
    i_req = 1'b0; d_req = 1'b0;
    check("t3_burst_count", 32'(ni + nd), 32'd4);
    check("t3_grant_count", 32'(done_who.size()), 32'd4);
    if (done_who.size() == 4) begin
      check("t3_grant0", 32'(done_who[0]), 32'd2);
      check("t3_grant1", 32'(done_who[1]), 32'd1);
      check("t3_grant2", 32'(done_who[2]), 32'd2);
      check("t3_grant3", 32'(done_who[3]), 32'd1);
    end
    step();

    // two wait cycles on word 2
    clear_logs();
    waits_left = 2;
    run_burst(1'b1, 1'b0, 32'h40, lat);
    check("t4_latency", 32'(lat), 32'd7);
    check("t4_hold_cycles", 32'(hold8), 32'd3);
    check_acks("t4", 32'h40);
    check("t4_d_rvalid_count", 32'(d_rv_cnt), 32'd4);
    step();

    // reset during word 1 of an I refill
    clear_logs();
    i_addr = 32'h204; i_req = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (mem_cs && word_idx == 2'd1) found = 1'b1;
    end
    if (!found) check("t5_word1_timeout", 32'd0, 32'd1);
    reset = 1'b1; i_req = 1'b0;
    step();
    reset = 1'b0;
    step(); step(); step();
    check("t5_no_i_done", 32'(i_done_cnt), 32'd0);
    clear_logs();
    run_burst(1'b0, 1'b0, 32'h204, lat);
    check("t5_latency", 32'(lat), 32'd5);
    check_acks("t5", 32'h200);
    check("t5_i_rvalid_count", 32'(i_rv_cnt), 32'd4);
    step();

    // I request held through done: a second independent burst follows
    clear_logs();
    i_addr = 32'h300; i_req = 1'b1;
    ni = 0; c1 = 0; c2 = 0;
    for (int n = 0; n < 60 && ni < 2; n++) begin
      step();
      if (i_done) begin
        ni++;
        if (ni == 1) c1 = cyc; else c2 = cyc;
      end
    end
    step();
    i_req = 1'b0;
    check("t6_done_count", 32'(ni), 32'd2);
    check("t6_done_spacing", 32'(c2 - c1), 32'd6);
    check("t6_i_rvalid_count", 32'(i_rv_cnt), 32'd8);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
